// File: rtl/gray_world_gain_ctrl.sv
// rtl/gray_world_gain_ctrl.sv - gray-world gain controller: per-frame RGB sums, sequential divide, frame-aligned apply
module gray_world_gain_ctrl #(
  parameter int Nrows = 480,
  parameter int Ncol  = 640,
  parameter int SUMW  = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic [23:0] s_axis_tdata,
  output logic [7:0]  quotR,
  output logic [7:0]  quotG,
  output logic [7:0]  quotB,
  output logic        busy,
  output logic        update_done,
  output logic        frame_err
);

  localparam int LW = $clog2(Nrows + 1);
  localparam int NW = SUMW + 8;

  if (SUMW < 8 + $clog2(Nrows * Ncol)) begin : g_bad_sumw
    $error("SUMW too small for one frame of 8-bit pixels");
  end

  typedef enum logic [2:0] {IDLE, LATCH, MIN, DIV_R, DIV_G, DIV_B} state_t;

  state_t            state_q, state_d;
  logic [SUMW-1:0]   acc_r_q, acc_g_q, acc_b_q;
  logic [SUMW-1:0]   sr_q, sg_q, sb_q;
  logic [LW-1:0]     line_cnt_q;
  logic              in_frame_q, pending_q, upd_q, err_q;
  logic [NW-1:0]     n_q, rem_q;
  logic [2:0]        cnt_q;
  logic [7:0]        qw_q, res_r_q, res_g_q;
  logic [7:0]        stg_r_q, stg_g_q, stg_b_q;
  logic [7:0]        quot_r_q, quot_g_q, quot_b_q;

  logic              sof, counted, frame_end, apply, qbit, last;
  logic [LW-1:0]     lines_after;
  logic [SUMW-1:0]   smin, div_src;
  logic [NW-1:0]     n_val, trial, rem_next;
  logic [7:0]        qfin;

  always_comb begin
    sof         = s_axis_tvalid & s_axis_tuser;
    counted     = sof | (s_axis_tvalid & in_frame_q);
    lines_after = sof ? LW'(s_axis_tlast) : line_cnt_q + LW'(s_axis_tlast);
    frame_end   = counted & s_axis_tlast & (lines_after == LW'(Nrows));
    // A SOF beat on the apply edge belongs to the new frame, so hold off.
    apply       = pending_q & ~in_frame_q & ~sof;

    smin = (sr_q < sg_q) ? sr_q : sg_q;
    if (sb_q < smin) smin = sb_q;
    n_val = {8'b0, smin} * NW'(255);

    case (state_q)
      DIV_G:   div_src = sg_q;
      DIV_B:   div_src = sb_q;
      default: div_src = sr_q;
    endcase
    // With a zero divisor every step succeeds, giving the required 255.
    trial    = {8'b0, div_src} << cnt_q;
    qbit     = (rem_q >= trial);
    rem_next = qbit ? rem_q - trial : rem_q;
    qfin     = {qw_q[6:0], qbit};
    last     = (cnt_q == 3'd0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_end) state_d = LATCH;
      LATCH:   state_d = MIN;
      MIN:     state_d = DIV_R;
      DIV_R:   if (last) state_d = DIV_G;
      DIV_G:   if (last) state_d = DIV_B;
      DIV_B:   if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_r_q    <= '0;
      acc_g_q    <= '0;
      acc_b_q    <= '0;
      sr_q       <= '0;
      sg_q       <= '0;
      sb_q       <= '0;
      line_cnt_q <= '0;
      in_frame_q <= 1'b0;
      pending_q  <= 1'b0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      n_q        <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      qw_q       <= '0;
      res_r_q    <= '0;
      res_g_q    <= '0;
      stg_r_q    <= '0;
      stg_g_q    <= '0;
      stg_b_q    <= '0;
      quot_r_q   <= 8'd255;
      quot_g_q   <= 8'd255;
      quot_b_q   <= 8'd255;
    end else begin
      state_q <= state_d;

      if (sof) begin
        acc_r_q <= SUMW'(s_axis_tdata[23:16]);
        acc_g_q <= SUMW'(s_axis_tdata[15:8]);
        acc_b_q <= SUMW'(s_axis_tdata[7:0]);
      end else if (s_axis_tvalid && in_frame_q) begin
        acc_r_q <= acc_r_q + SUMW'(s_axis_tdata[23:16]);
        acc_g_q <= acc_g_q + SUMW'(s_axis_tdata[15:8]);
        acc_b_q <= acc_b_q + SUMW'(s_axis_tdata[7:0]);
      end
      if (counted) line_cnt_q <= lines_after;
      if (frame_end)  in_frame_q <= 1'b0;
      else if (sof)   in_frame_q <= 1'b1;
      err_q <= (sof & in_frame_q) | (frame_end & (state_q != IDLE));

      case (state_q)
        LATCH: begin
          sr_q <= acc_r_q;
          sg_q <= acc_g_q;
          sb_q <= acc_b_q;
        end
        MIN: begin
          n_q   <= n_val;
          rem_q <= n_val;
          cnt_q <= 3'd7;
        end
        DIV_R, DIV_G, DIV_B: begin
          rem_q <= last ? n_q : rem_next;
          cnt_q <= cnt_q - 3'd1;
          qw_q  <= qfin;
          if (last && state_q == DIV_R) res_r_q <= qfin;
          if (last && state_q == DIV_G) res_g_q <= qfin;
        end
        default: ;
      endcase

      if (state_q == DIV_B && last) begin
        stg_r_q   <= res_r_q;
        stg_g_q   <= res_g_q;
        stg_b_q   <= qfin;
        pending_q <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
      if (apply) begin
        quot_r_q <= stg_r_q;
        quot_g_q <= stg_g_q;
        quot_b_q <= stg_b_q;
      end
      upd_q <= apply;
    end
  end

  assign quotR       = quot_r_q;
  assign quotG       = quot_g_q;
  assign quotB       = quot_b_q;
  assign busy        = (state_q != IDLE);
  assign update_done = upd_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_gray_world_gain_ctrl.sv
// tb/tb_gray_world_gain_ctrl.sv - scoreboard bench for gray_world_gain_ctrl
module tb_gray_world_gain_ctrl;
  localparam int NROWS = 4;
  localparam int NCOL  = 8;
  localparam int SUMW  = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid, s_axis_tuser, s_axis_tlast;
  logic [23:0] s_axis_tdata;
  logic [7:0]  quotR, quotG, quotB;
  logic        busy, update_done, frame_err;

  gray_world_gain_ctrl #(.Nrows(NROWS), .Ncol(NCOL), .SUMW(SUMW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .quotR(quotR), .quotG(quotG), .quotB(quotB),
    .busy(busy), .update_done(update_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, e0_cyc = 0, err_cnt = 0, busy_run = 0;
  bit          tb_in_frame = 0, chk_lat = 0, skip_busy = 0, mid_chg = 0;
  logic [23:0] exp_val, prev_q = 24'hFFFFFF;
  logic [23:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gain(input longint smin, input longint sx);
    if (sx == 0) return 8'd255;
    return 8'((255 * smin) / sx);
  endfunction

  always @(negedge clk) begin
    logic [23:0] e;
    if (update_done) begin
      if (sb_q.size() == 0) check("upd_unexpected", 1, 0);
      else begin
        e = sb_q.pop_front();
        check("quotR", quotR, e[23:16]);
        check("quotG", quotG, e[15:8]);
        check("quotB", quotB, e[7:0]);
        if (chk_lat) check("upd_latency", cyc - e0_cyc, 27);
      end
    end
    if (frame_err) err_cnt++;
    if (tb_in_frame && {quotR, quotG, quotB} != prev_q) mid_chg = 1;
    prev_q = {quotR, quotG, quotB};
    if (busy) busy_run++;
    else if (busy_run > 0) begin
      if (!skip_busy) check("busy_len", busy_run, 26);
      busy_run = 0;
    end
  end

  task automatic idle_cycle();
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'($urandom);
    s_axis_tlast  = 1'($urandom);
    s_axis_tdata  = 24'($urandom);
    @(posedge clk); #1;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int lines, input bit rnd, input logic [23:0] px, input int gap);
    longint sr = 0, sg = 0, sb = 0, mn;
    logic [23:0] p;
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < NCOL; c++) begin
        while (gap > 0 && $urandom_range(99) < gap) idle_cycle();
        p = rnd ? 24'($urandom) : px;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = (l == 0 && c == 0);
        s_axis_tlast  = (c == NCOL - 1);
        s_axis_tdata  = p;
        @(posedge clk); #1;
        if (l == 0 && c == 0) tb_in_frame = 1;
        sr += p[23:16];
        sg += p[15:8];
        sb += p[7:0];
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    if (lines == NROWS) begin
      tb_in_frame = 0;
      e0_cyc = cyc;
    end
    mn = (sr < sg) ? sr : sg;
    if (sb < mn) mn = sb;
    exp_val = {gain(mn, sr), gain(mn, sg), gain(mn, sb)};
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check(tag, sb_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_quotR", quotR, 255);
    check("rst_quotG", quotG, 255);
    check("rst_quotB", quotB, 255);
    check("rst_busy", busy, 0);
    check("rst_upd", update_done, 0);
    check("rst_err", frame_err, 0);

    chk_lat = 1;
    send_frame(NROWS, 0, {8'd200, 8'd100, 8'd50}, 0);
    sb_q.push_back({8'd63, 8'd127, 8'd255});
    drain("drain_basic");
    chk_lat = 0;

    send_frame(NROWS, 0, {8'd128, 8'd128, 8'd128}, 0);
    sb_q.push_back(24'hFFFFFF);
    drain("drain_gray");
    send_frame(NROWS, 0, 24'h000000, 0);
    sb_q.push_back(24'hFFFFFF);
    drain("drain_black");

    send_frame(3, 0, {8'd10, 8'd20, 8'd30}, 0);
    send_frame(NROWS, 0, {8'd200, 8'd100, 8'd50}, 0);
    sb_q.push_back({8'd63, 8'd127, 8'd255});
    drain("drain_short");
    check("short_err_cnt", err_cnt, 1);

    send_frame(NROWS, 1, 24'h0, 0);
    repeat (9) @(posedge clk);
    #1;
    skip_busy = 1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_quotR", quotR, 255);
    check("abort_quotG", quotG, 255);
    check("abort_quotB", quotB, 255);
    check("abort_busy", busy, 0);
    repeat (40) @(posedge clk);
    #1 skip_busy = 0;
    send_frame(NROWS, 1, 24'h0, 0);
    sb_q.push_back(exp_val);
    drain("drain_after_rst");

    mid_chg = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(NROWS, f != 0, {8'd200, 8'd100, 8'd50}, 0);
      sb_q.push_back(exp_val);
      idle_cycle();
      idle_cycle();
    end
    drain("drain_b2b");
    check("b2b_mid_frame_change", mid_chg, 0);

    for (int f = 0; f < 3; f++) begin
      send_frame(NROWS, 1, 24'h0, 50);
      sb_q.push_back(exp_val);
      drain("drain_gaps");
    end
    check("err_total", err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end
endmodule
